// File: rtl/chip_dac_rx_if.sv
// rtl/chip_dac_rx_if.sv - DAC link pins and decoded frame outputs (dac_levels only with CHIP_DAC_RX_REGFILE_EN)
interface chip_dac_rx_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              chip_rst;
    logic              chip_clk;
    logic              chip_data_in;
    logic              busy;
    logic              frame_valid;
    logic              frame_abort;
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
    logic [15:0]       frame_cnt;
`ifdef CHIP_DAC_RX_REGFILE_EN
    logic [(2**ADDR_W)*DATA_W-1:0] dac_levels;

    modport master (
        output chip_rst, chip_clk, chip_data_in,
        input  busy, frame_valid, frame_abort, frame_addr, frame_data, frame_cnt, dac_levels
    );
    modport slave (
        input  chip_rst, chip_clk, chip_data_in,
        output busy, frame_valid, frame_abort, frame_addr, frame_data, frame_cnt, dac_levels
    );
`else
    modport master (
        output chip_rst, chip_clk, chip_data_in,
        input  busy, frame_valid, frame_abort, frame_addr, frame_data, frame_cnt
    );
    modport slave (
        input  chip_rst, chip_clk, chip_data_in,
        output busy, frame_valid, frame_abort, frame_addr, frame_data, frame_cnt
    );
`endif
endinterface

// File: rtl/chip_dac_rx.sv
// rtl/chip_dac_rx.sv - oversampling 3-wire DAC link receiver; CHIP_DAC_RX_REGFILE_EN adds the per-DAC level bank
module chip_dac_rx #(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16384
) (
    input  logic         clk,
    input  logic         rst,
    chip_dac_rx_if.slave link
);
    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {LINK_RST, IDLE, ADDR, DATA, COMMIT} state_t;

    // [0] is the first synchronizer stage; clk_sync[2] is the edge-detect history
    logic [2:0]         clk_sync_q, clk_sync_d;
    logic [1:0]         data_sync_q, data_sync_d;
    logic [1:0]         rst_sync_q, rst_sync_d;
    logic               fall_q, fall_d;
    logic               bit_q, bit_d;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               abort_q, abort_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [15:0]        cnt_q, cnt_d;
`ifdef CHIP_DAC_RX_REGFILE_EN
    localparam int BANK_W = (2**ADDR_W) * DATA_W;
    logic [BANK_W-1:0]  bank_q, bank_d;
`endif

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], link.chip_clk};
        data_sync_d = {data_sync_q[0], link.chip_data_in};
        rst_sync_d  = {rst_sync_q[0], link.chip_rst};
        fall_d      = clk_sync_q[2] & ~clk_sync_q[1];
        bit_d       = fall_d ? data_sync_q[1] : bit_q;

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        tmo_d     = '0;
        valid_d   = 1'b0;
        abort_d   = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
`ifdef CHIP_DAC_RX_REGFILE_EN
        bank_d    = bank_q;
`endif

        case (state_q)
            LINK_RST: if (rst_sync_q[1]) state_d = IDLE;
            IDLE: begin
                if (fall_q && !bit_q) begin
                    state_d   = ADDR;
                    bit_cnt_d = '0;
                    sr_d      = '0;
                end
            end
            ADDR, DATA: begin
                tmo_d = tmo_q + 1'b1;
                if (fall_q) begin
                    tmo_d     = '0;
                    sr_d      = {bit_q, sr_q[FRAME_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (state_q == ADDR && bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                    if (state_q == DATA && bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = COMMIT;
                        valid_d = 1'b1;
                        addr_d  = sr_d[ADDR_W-1:0];
                        data_d  = sr_d[FRAME_W-1:ADDR_W];
`ifdef CHIP_DAC_RX_REGFILE_EN
                        bank_d[int'(addr_d) * DATA_W +: DATA_W] = data_d;
`endif
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC)) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                    tmo_d   = '0;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                cnt_d   = cnt_q + 16'd1;
            end
            default: state_d = LINK_RST;
        endcase

        // Link reset overrides everything, including a last bit sampled this same cycle
        if (!rst_sync_q[1]) begin
            state_d = LINK_RST;
            valid_d = 1'b0;
            abort_d = (state_q == ADDR) || (state_q == DATA);
            addr_d  = addr_q;
            data_d  = data_q;
            tmo_d   = '0;
`ifdef CHIP_DAC_RX_REGFILE_EN
            bank_d  = '0;
`endif
        end

        busy_d = (state_d == ADDR) || (state_d == DATA) || (state_d == COMMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            rst_sync_q  <= '0;
            fall_q      <= 1'b0;
            bit_q       <= 1'b0;
            state_q     <= LINK_RST;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            tmo_q       <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            abort_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
`ifdef CHIP_DAC_RX_REGFILE_EN
            bank_q      <= '0;
`endif
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            rst_sync_q  <= rst_sync_d;
            fall_q      <= fall_d;
            bit_q       <= bit_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            abort_q     <= abort_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
`ifdef CHIP_DAC_RX_REGFILE_EN
            bank_q      <= bank_d;
`endif
        end
    end

    assign link.busy        = busy_q;
    assign link.frame_valid = valid_q;
    assign link.frame_abort = abort_q;
    assign link.frame_addr  = addr_q;
    assign link.frame_data  = data_q;
    assign link.frame_cnt   = cnt_q;
`ifdef CHIP_DAC_RX_REGFILE_EN
    assign link.dac_levels  = bank_q;
`endif
endmodule

// File: tb/tb_chip_dac_rx.sv
// tb/tb_chip_dac_rx.sv - randomized link frames against a frame-level model of chip_dac_rx
`timescale 1ns/1ps
module tb_chip_dac_rx;
    localparam int ADDR_W      = 3;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 16384;

    logic clk = 1'b0;
    logic rst = 1'b0;

    chip_dac_rx_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) link();

    chip_dac_rx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference model
    logic [7:0]  exp_bank [8];
    logic [15:0] exp_cnt;
    logic [2:0]  exp_addr;
    logic [7:0]  exp_data;

    function automatic void model_commit(input logic [2:0] a, input logic [7:0] d);
        exp_bank[a] = d;
        exp_addr    = a;
        exp_data    = d;
        exp_cnt     = exp_cnt + 16'd1;
    endfunction

    function automatic void model_clear_bank();
        for (int i = 0; i < 8; i++) exp_bank[i] = 8'h00;
    endfunction

    // Output monitor
    int          cyc = 0;
    int          n_valid = 0, n_abort = 0, n_both = 0;
    int          valid_cyc = 0;
    logic [15:0] cnt_at_valid = 0, cnt_after = 0;
    logic        pend = 1'b0;
    logic [10:0] got_q [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (pend) begin
            cnt_after = link.frame_cnt;
            pend = 1'b0;
        end
        if (link.frame_valid) begin
            n_valid++;
            valid_cyc = cyc;
            got_q.push_back({link.frame_addr, link.frame_data});
            cnt_at_valid = link.frame_cnt;
            pend = 1'b1;
        end
        if (link.frame_abort) n_abort++;
        if (link.frame_valid && link.frame_abort) n_both++;
    end

    // Link driver: data changes with the rising chip_clk, receiver samples on the fall
    int last_fall_cyc = 0;

    task automatic send_bits(input logic [31:0] bits, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            link.chip_clk     = 1'b1;
            link.chip_data_in = bits[i];
            repeat (half) @(posedge clk);
            #2;
            link.chip_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (half - 1) @(posedge clk);
        end
    endtask

    function automatic logic [31:0] frame_bits(input logic [2:0] a, input logic [7:0] d);
        logic [31:0] b;
        b       = '0;
        b[3:1]  = a;
        b[11:4] = d;
        return b;
    endfunction

    task automatic send_frame(input logic [2:0] a, input logic [7:0] d, input int half);
        send_bits(frame_bits(a, d), 12, half);
        #1 link.chip_data_in = 1'b1;
    endtask

    task automatic verify_frame(input string tag, input logic [2:0] a, input logic [7:0] d);
        logic [10:0] g;
        check({tag, "_nvalid"}, 64'(got_q.size()), 64'd1);
        if (got_q.size() != 0) begin
            g = got_q.pop_front();
            check({tag, "_word"}, 64'(g), 64'({a, d}));
        end
        got_q.delete();
    endtask

    task automatic check_state(input string tag);
        logic [63:0] lv;
        @(negedge clk);
        check({tag, "_addr"}, 64'(link.frame_addr), 64'(exp_addr));
        check({tag, "_data"}, 64'(link.frame_data), 64'(exp_data));
        check({tag, "_cnt"},  64'(link.frame_cnt),  64'(exp_cnt));
        check({tag, "_busy"}, 64'(link.busy),       64'd0);
        for (int i = 0; i < 8; i++) lv[i*8 +: 8] = exp_bank[i];
`ifdef CHIP_DAC_RX_REGFILE_EN
        check({tag, "_levels"}, link.dac_levels, lv);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(link.busy),        64'd0);
        check({tag, "_valid"}, 64'(link.frame_valid), 64'd0);
        check({tag, "_abort"}, 64'(link.frame_abort), 64'd0);
        check({tag, "_addr"},  64'(link.frame_addr),  64'd0);
        check({tag, "_data"},  64'(link.frame_data),  64'd0);
        check({tag, "_cnt"},   64'(link.frame_cnt),   64'd0);
`ifdef CHIP_DAC_RX_REGFILE_EN
        check({tag, "_levels"}, link.dac_levels, 64'd0);
`endif
    endtask

    initial begin
        int base_v, base_a;
        logic [2:0] ra;
        logic [7:0] rd;

        link.chip_rst     = 1'b0;
        link.chip_clk     = 1'b0;
        link.chip_data_in = 1'b1;
        exp_cnt  = 16'd0;
        exp_addr = 3'd0;
        exp_data = 8'd0;
        model_clear_bank();

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");

        rst = 1'b1;
        link.chip_rst = 1'b1;
        repeat (6) @(posedge clk);

        // Preamble then one frame, with latency and counter-step checks
        send_bits(32'hFFFF_FFFF, 3, 5);
        send_frame(3'b101, 8'hA5, 5);
        repeat (6) @(posedge clk);
        check("first_latency", 64'(valid_cyc - last_fall_cyc), 64'd4);
        check("first_cnt_step", 64'(cnt_after), 64'(cnt_at_valid + 16'd1));
        verify_frame("first", 3'b101, 8'hA5);
        model_commit(3'b101, 8'hA5);
        check_state("first");

        // Back-to-back frames at the minimum bit period
        send_frame(3'd0, 8'h01, 4);
        send_frame(3'd7, 8'hFF, 4);
        repeat (6) @(posedge clk);
        check("b2b_nvalid", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            check("b2b_w0", 64'(got_q[0]), 64'({3'd0, 8'h01}));
            check("b2b_w1", 64'(got_q[1]), 64'({3'd7, 8'hFF}));
        end
        got_q.delete();
        model_commit(3'd0, 8'h01);
        model_commit(3'd7, 8'hFF);
        check_state("b2b");

        // Link reset after 5 data bits
        base_v = n_valid;
        base_a = n_abort;
        send_bits(frame_bits(3'd2, 8'h5A), 9, 5);
        @(posedge clk); #2 link.chip_rst = 1'b0;
        link.chip_data_in = 1'b1;
        repeat (6) @(posedge clk);
        #2 link.chip_rst = 1'b1;
        repeat (8) @(posedge clk);
        check("lrst_abort", 64'(n_abort - base_a), 64'd1);
        check("lrst_valid", 64'(n_valid - base_v), 64'd0);
        model_clear_bank();
        check_state("lrst");

        // Timeout after 2 address bits
        base_v = n_valid;
        base_a = n_abort;
        send_bits(frame_bits(3'd6, 8'h11), 3, 5);
        repeat (TIMEOUT_CYC - 16) @(posedge clk);
        check("tmo_early", 64'(n_abort - base_a), 64'd0);
        repeat (24) @(posedge clk);
        check("tmo_abort", 64'(n_abort - base_a), 64'd1);
        check("tmo_valid", 64'(n_valid - base_v), 64'd0);
        #1 link.chip_data_in = 1'b1;
        send_frame(3'd3, 8'h3C, 5);
        repeat (6) @(posedge clk);
        verify_frame("post_tmo", 3'd3, 8'h3C);
        model_commit(3'd3, 8'h3C);
        check_state("post_tmo");

        // System reset mid-DATA
        send_bits(frame_bits(3'd4, 8'h77), 7, 5);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check_all_zero("sysrst");
        link.chip_data_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (6) @(posedge clk);
        exp_cnt  = 16'd0;
        exp_addr = 3'd0;
        exp_data = 8'd0;
        model_clear_bank();
        got_q.delete();
        send_frame(3'd1, 8'h42, 6);
        repeat (6) @(posedge clk);
        verify_frame("after_rst", 3'd1, 8'h42);
        model_commit(3'd1, 8'h42);
        check_state("after_rst");

        // Randomized frames with random bit period and idle gap
        for (int k = 0; k < 20; k++) begin
            ra = 3'($urandom_range(0, 7));
            rd = 8'($urandom_range(0, 255));
            send_bits(32'hFFFF_FFFF, $urandom_range(0, 3), 4);
            send_frame(ra, rd, $urandom_range(4, 7));
            repeat (6) @(posedge clk);
            verify_frame($sformatf("rnd%0d", k), ra, rd);
            model_commit(ra, rd);
            check_state($sformatf("rnd%0d", k));
        end

        // Counter wrap
        @(negedge clk) force dut.cnt_q = 16'hFFFF;
        @(negedge clk) release dut.cnt_q;
        exp_cnt = 16'hFFFF;
        check_state("preload");
        send_frame(3'd6, 8'hC3, 5);
        repeat (6) @(posedge clk);
        verify_frame("wrap", 3'd6, 8'hC3);
        model_commit(3'd6, 8'hC3);
        check_state("wrap");

        check("valid_abort_overlap", 64'(n_both), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
